// File: rtl/seq_pattern_detector_pkg.sv
// Shared definitions for the serial pattern detector: mode encodings,
// the observable detector phase and the slot-index width helper.
package seq_det_pkg;

   localparam logic MODE_FRAMED  = 1'b0;
   localparam logic MODE_SLIDING = 1'b1;

   // Detector phase. COLLECT/DECIDE belong to framed mode and FILL/RUN to
   // sliding mode, so the phase also carries the registered mode copy.
   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_DECIDE  = 2'd1,
      ST_FILL    = 2'd2,
      ST_RUN     = 2'd3
   } det_state_e;

   // Width of a slot index: $clog2(n), but never less than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seq_pattern_detector_if.sv
// Bundle of the detector's data, pattern-programming and result signals.
// Handshake: a serial bit is consumed on a rising edge only when in_vld=1;
// there is no back-pressure, so the detector is always ready. dec, dec_id
// and frame_end are combinational in the same cycle as the qualifying bit.
interface seq_pattern_detector_if #(
   parameter int LEN   = 4,
   parameter int NPAT  = 3,
   parameter int CNT_W = 8
) ();
   import seq_det_pkg::*;

   localparam int IDX_W = idx_width(NPAT);

   logic             in_vld;
   logic             in;
   logic             mode;
   logic             pat_we;
   logic [IDX_W-1:0] pat_idx;
   logic [LEN-1:0]   pat_data;
   logic             pat_en;
   logic             dec;
   logic [IDX_W-1:0] dec_id;
   logic             frame_end;
   logic [CNT_W-1:0] match_cnt;
   det_state_e       dbg_state;

   modport master (
      output in_vld, in, mode, pat_we, pat_idx, pat_data, pat_en,
      input  dec, dec_id, frame_end, match_cnt, dbg_state
   );

   modport slave (
      input  in_vld, in, mode, pat_we, pat_idx, pat_data, pat_en,
      output dec, dec_id, frame_end, match_cnt, dbg_state
   );

endinterface

// File: rtl/seq_pattern_detector_bank.sv
// Pattern bank: NPAT programmable LEN-bit patterns with enables, the
// per-slot compare against the candidate window and the lowest-index
// priority encoder.
module seq_pat_bank #(
   parameter int LEN   = 4,
   parameter int NPAT  = 3,
   parameter int IDX_W = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_we,
   input  logic [IDX_W-1:0] i_idx,
   input  logic [LEN-1:0]   i_data,
   input  logic             i_en,
   input  logic [LEN-1:0]   i_cand,
   output logic [NPAT-1:0]  o_hit,
   output logic [IDX_W-1:0] o_id
);
   import seq_det_pkg::*;

   logic [LEN-1:0]  r_pat [NPAT];
   logic [NPAT-1:0] r_en;
   logic            w_wr_ok;

   // Out-of-range slot numbers are silently dropped.
   assign w_wr_ok = i_we && (int'(i_idx) < NPAT);

   // Slot storage; a write lands at the edge, so a compare in the same
   // cycle still sees the previous contents.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int k = 0; k < NPAT; k++) begin
            r_pat[k] <= '0;
         end
         r_en <= '0;
      end else begin
         for (int k = 0; k < NPAT; k++) begin
            if (w_wr_ok && (i_idx == IDX_W'(k))) begin
               r_pat[k] <= i_data;
               r_en[k]  <= i_en;
            end
         end
      end
   end

   // Per-slot hit: enabled and equal to the candidate window.
   always_comb begin
      o_hit = '0;
      for (int k = 0; k < NPAT; k++) begin
         o_hit[k] = r_en[k] && (r_pat[k] == i_cand);
      end
   end

   // Lowest hitting slot wins; scanning downwards lets the lowest overwrite.
   always_comb begin
      o_id = '0;
      for (int k = NPAT - 1; k >= 0; k--) begin
         if (o_hit[k]) begin
            o_id = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/seq_pattern_detector.sv
// Mealy serial-pattern detector. Framed mode checks non-overlapping
// LEN-bit frames; sliding mode checks every LEN-bit window once the
// history is full. Reports the matching slot and a saturating match count.
module seq_pattern_detector #(
   parameter int LEN   = 4,
   parameter int NPAT  = 3,
   parameter int CNT_W = 8
) (
   input logic                   clk,
   input logic                   rst,
   seq_pattern_detector_if.slave bus
);
   import seq_det_pkg::*;

   localparam int IDX_W = idx_width(NPAT);
   localparam int POS_W = $clog2(LEN);
   // Position of the bit just before the frame's last bit; reaching it in
   // COLLECT means the next valid bit completes the frame, and reaching it
   // in FILL means the history is full after this bit.
   localparam logic [POS_W-1:0] POS_PRE = POS_W'(LEN - 2);

   det_state_e       r_state;
   det_state_e       w_state_n;
   logic [POS_W-1:0] r_pos;
   logic [POS_W-1:0] w_pos_n;
   logic [LEN-2:0]   r_hist;
   logic [LEN-2:0]   w_hist_n;
   logic [CNT_W-1:0] r_cnt;

   logic             w_mode_q;
   logic             w_mode_chg;
   logic [LEN-1:0]   w_cand;
   logic [NPAT-1:0]  w_hit;
   logic             w_hit_any;
   logic [IDX_W-1:0] w_hit_id;
   logic             w_dec;
   logic             w_frame_end;

   // Sliding-mode phases imply mode_q=1, framed phases mode_q=0.
   assign w_mode_q   = (r_state == ST_FILL) || (r_state == ST_RUN);
   assign w_mode_chg = (bus.mode != w_mode_q);
   assign w_cand     = {r_hist, bus.in};
   assign w_hit_any  = |w_hit;

   seq_pat_bank #(
      .LEN   (LEN),
      .NPAT  (NPAT),
      .IDX_W (IDX_W)
   ) u_bank (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_we   (bus.pat_we),
      .i_idx  (bus.pat_idx),
      .i_data (bus.pat_data),
      .i_en   (bus.pat_en),
      .i_cand (w_cand),
      .o_hit  (w_hit),
      .o_id   (w_hit_id)
   );

   // Next-state and Mealy outputs: a mode change restarts detection and
   // swallows the current bit; otherwise each valid bit advances the phase.
   always_comb begin
      w_state_n   = r_state;
      w_pos_n     = r_pos;
      w_hist_n    = r_hist;
      w_dec       = 1'b0;
      w_frame_end = 1'b0;
      if (w_mode_chg) begin
         w_state_n = (bus.mode == MODE_SLIDING) ? ST_FILL : ST_COLLECT;
         w_pos_n   = '0;
         w_hist_n  = '0;
      end else if (bus.in_vld) begin
         w_hist_n = w_cand[LEN-2:0];
         case (r_state)
            ST_COLLECT: begin
               w_pos_n = r_pos + 1'b1;
               if (r_pos == POS_PRE) begin
                  w_state_n = ST_DECIDE;
               end
            end
            ST_DECIDE: begin
               w_dec       = w_hit_any;
               w_frame_end = 1'b1;
               w_pos_n     = '0;
               w_state_n   = ST_COLLECT;
            end
            ST_FILL: begin
               if (r_pos == POS_PRE) begin
                  w_pos_n   = '0;
                  w_state_n = ST_RUN;
               end else begin
                  w_pos_n = r_pos + 1'b1;
               end
            end
            ST_RUN: begin
               w_dec = w_hit_any;
            end
            default: begin
               w_state_n = ST_COLLECT;
               w_pos_n   = '0;
            end
         endcase
      end
      if (rst) begin
         w_dec       = 1'b0;
         w_frame_end = 1'b0;
      end
   end

   // Phase, position, history and saturating match counter; reset adopts
   // the current mode input and clears everything else.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= (bus.mode == MODE_SLIDING) ? ST_FILL : ST_COLLECT;
         r_pos   <= '0;
         r_hist  <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_n;
         r_pos   <= w_pos_n;
         r_hist  <= w_hist_n;
         if (w_dec && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign bus.dec       = w_dec;
   assign bus.dec_id    = w_dec ? w_hit_id : '0;
   assign bus.frame_end = w_frame_end;
   assign bus.match_cnt = r_cnt;
   assign bus.dbg_state = r_state;

endmodule
